// File: rtl/conv_1d_pkg.sv
// Shared types and helpers for the 1-D BRAM convolution control path.
// State encoding for the controller FSM plus a clamped clog2 for port widths.
package conv_1d_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      LOAD  = 2'd1,
      DRAIN = 2'd2,
      DONE  = 2'd3
   } state_t;

   // A width of zero is never legal for a port, so single-entry spaces still get one bit.
   function automatic int clog2w(input int n);
      int r;
      r = $clog2(n);
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/conv_1d_window_tracker.sv
// Follows the shift-in strobe of the window register and flags each completed,
// stride-aligned window together with its result index.
module conv_1d_window_tracker
   import conv_1d_pkg::*;
#(
   parameter int FILTER_L = 3,
   parameter int STRIDE_W = 1,
   parameter int ADDR_W   = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              shift,
   output logic              win_end,
   output logic [ADDR_W-1:0] result_idx
);

   localparam int FILL_W = clog2w(FILTER_L);
   localparam int PHASE_W = clog2w(STRIDE_W);
   localparam logic [FILL_W-1:0]  FILL_LAST  = FILL_W'(FILTER_L - 1);
   localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(STRIDE_W - 1);

   logic [FILL_W-1:0]  fill;
   logic [PHASE_W-1:0] phase;
   logic [ADDR_W-1:0]  res_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         fill       <= '0;
         phase      <= '0;
         res_cnt    <= '0;
         win_end    <= 1'b0;
         result_idx <= '0;
      end else if (clear) begin
         fill       <= '0;
         phase      <= '0;
         res_cnt    <= '0;
         win_end    <= 1'b0;
         result_idx <= '0;
      end else begin
         win_end <= 1'b0;
         if (shift) begin
            if (fill != FILL_LAST) begin
               fill <= fill + 1'b1;
            end else begin
               // Phase 0 marks a stride-aligned window end; counting starts at the first full window.
               if (phase == '0) begin
                  win_end    <= 1'b1;
                  result_idx <= res_cnt;
                  res_cnt    <= res_cnt + 1'b1;
               end
               phase <= (phase == PHASE_LAST) ? '0 : phase + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/conv_bram_1d_ctrl.sv
// Control unit for the 1-D BRAM convolution engine: column reads, shift steering, result writes.
// Optional CONV_1D_CTRL_STALL_EN adds img_stall, which pauses column reads during LOAD.
module conv_bram_1d_ctrl
   import conv_1d_pkg::*;
#(
   parameter int IMG_W    = 32,
   parameter int FILTER_L = 3,
   parameter int STRIDE_W = 1,
   localparam int RESULT_W              = (IMG_W - FILTER_L) / STRIDE_W + 1,
   localparam int IMG_RAM_ADDR_WIDTH    = clog2w(IMG_W),
   localparam int RESULT_RAM_ADDR_WIDTH = clog2w(RESULT_W)
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start,
   input  logic                             last_val,
`ifdef CONV_1D_CTRL_STALL_EN
   input  logic                             img_stall,
`endif
   output logic [IMG_RAM_ADDR_WIDTH-1:0]    img_rdaddr,
   output logic                             img_rden,
   output logic                             dpath_sr_wren,
   output logic [RESULT_RAM_ADDR_WIDTH-1:0] dpath_result_wraddr,
   output logic                             dpath_result_wren,
   output logic                             busy,
   output logic                             done
);

   localparam logic [IMG_RAM_ADDR_WIDTH-1:0] COL_LAST = IMG_RAM_ADDR_WIDTH'(IMG_W - 1);

   state_t state;
   logic   stall;
   logic   run_clear;

`ifdef CONV_1D_CTRL_STALL_EN
   assign stall = img_stall;
`else
   assign stall = 1'b0;
`endif

   assign run_clear = (state == IDLE) && start;

   // img_rdaddr doubles as the column counter: it always holds the last column issued.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         img_rdaddr    <= '0;
         img_rden      <= 1'b0;
         dpath_sr_wren <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
      end else begin
         dpath_sr_wren <= img_rden;
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= LOAD;
                  img_rden   <= 1'b1;
                  img_rdaddr <= '0;
                  busy       <= 1'b1;
               end
            end
            LOAD: begin
               if (img_rdaddr == COL_LAST) begin
                  state    <= DRAIN;
                  img_rden <= 1'b0;
               end else if (stall) begin
                  img_rden <= 1'b0;
               end else begin
                  img_rden   <= 1'b1;
                  img_rdaddr <= img_rdaddr + 1'b1;
               end
            end
            DRAIN: begin
               if (last_val) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               state      <= IDLE;
               done       <= 1'b0;
               busy       <= 1'b0;
               img_rdaddr <= '0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   conv_1d_window_tracker #(
      .FILTER_L (FILTER_L),
      .STRIDE_W (STRIDE_W),
      .ADDR_W   (RESULT_RAM_ADDR_WIDTH)
   ) u_tracker (
      .clk        (clk),
      .reset      (reset),
      .clear      (run_clear),
      .shift      (dpath_sr_wren),
      .win_end    (dpath_result_wren),
      .result_idx (dpath_result_wraddr)
   );

endmodule

// File: tb/tb_conv_bram_1d_ctrl.sv
// Bench for conv_bram_1d_ctrl: three parameter sets run in lockstep against a cycle-level model.
// Build with CONV_1D_CTRL_STALL_EN defined to exercise the img_stall port as well.
module tb_conv_bram_1d_ctrl;

   localparam int NC   = 3;
   localparam int MAXC = 48;
   localparam int CW [NC] = '{8, 10, 4};
   localparam int CF [NC] = '{3, 3, 4};
   localparam int CS [NC] = '{1, 2, 1};
   localparam int EXP_PULSES [NC] = '{6, 4, 1};
`ifdef CONV_1D_CTRL_STALL_EN
   localparam bit STALL_ON = 1'b1;
`else
   localparam bit STALL_ON = 1'b0;
`endif

   typedef struct {
      int         lv;
      int         lv_early;
      int         rep_a;
      int         rep_b;
      logic [15:0] stall_mask;
      int         exp_done;
   } scen_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start = 1'b0;
   logic last_val = 1'b0;
`ifdef CONV_1D_CTRL_STALL_EN
   logic img_stall = 1'b0;
`endif

   logic       busy_a [NC];
   logic       done_a [NC];
   logic       rden_a [NC];
   logic       sr_a   [NC];
   logic       wren_a [NC];
   logic [7:0] addr_a [NC];
   logic [7:0] waddr_a[NC];

   int vectors = 0;
   int miscompares = 0;

   // {busy, done, rden, sr_wren, result_wren, rdaddr[7:0], result_wraddr[7:0]}
   logic [20:0] exp_vec [NC][MAXC];
   int          exp_done_cyc [NC];
   int          run_len;

   always #5 clk = ~clk;

   for (genvar gi = 0; gi < NC; gi++) begin : g_dut
      localparam int RW = (CW[gi] - CF[gi]) / CS[gi] + 1;
      localparam int AW = conv_1d_pkg::clog2w(CW[gi]);
      localparam int WW = conv_1d_pkg::clog2w(RW);
      logic [AW-1:0] rdaddr;
      logic [WW-1:0] wraddr;
      logic rden, sr, wren, bsy, dn;

      conv_bram_1d_ctrl #(
         .IMG_W    (CW[gi]),
         .FILTER_L (CF[gi]),
         .STRIDE_W (CS[gi])
      ) u_dut (
         .clk                 (clk),
         .reset               (reset),
         .start               (start),
         .last_val            (last_val),
`ifdef CONV_1D_CTRL_STALL_EN
         .img_stall           (img_stall),
`endif
         .img_rdaddr          (rdaddr),
         .img_rden            (rden),
         .dpath_sr_wren       (sr),
         .dpath_result_wraddr (wraddr),
         .dpath_result_wren   (wren),
         .busy                (bsy),
         .done                (dn)
      );

      assign busy_a[gi]  = bsy;
      assign done_a[gi]  = dn;
      assign rden_a[gi]  = rden;
      assign sr_a[gi]    = sr;
      assign wren_a[gi]  = wren;
      assign addr_a[gi]  = 8'(rdaddr);
      assign waddr_a[gi] = 8'(wraddr);
   end

   function automatic logic stall_at(input scen_t s, input int c);
      if (c < 0 || c > 15) return 1'b0;
      return STALL_ON & s.stall_mask[c];
   endfunction

   // Reference: columns are issued one per unstalled cycle, data arrives a cycle later,
   // and a window ending at column p writes result (p-(L-1))/S one cycle after its shift.
   task automatic build_model(input scen_t s);
      int issue_cyc [16];
      int issued, last_issue, dn, mx;
      mx = 0;
      for (int d = 0; d < NC; d++) begin
         for (int c = 0; c < MAXC; c++) exp_vec[d][c] = '0;
         issued = 0;
         last_issue = 0;
         for (int c = 1; c < MAXC && issued < CW[d]; c++) begin
            if (c == 1 || !stall_at(s, c - 1)) begin
               issue_cyc[issued] = c;
               exp_vec[d][c][18] = 1'b1;
               exp_vec[d][c][15:8] = 8'(issued);
               issued++;
               last_issue = c;
            end
         end
         for (int p = 0; p < CW[d]; p++) begin
            exp_vec[d][issue_cyc[p] + 1][17] = 1'b1;
            if (p >= CF[d] - 1 && (p - (CF[d] - 1)) % CS[d] == 0) begin
               exp_vec[d][issue_cyc[p] + 2][16] = 1'b1;
               exp_vec[d][issue_cyc[p] + 2][7:0] = 8'((p - (CF[d] - 1)) / CS[d]);
            end
         end
         dn = -1;
         for (int c = last_issue + 1; c < MAXC - 5 && dn < 0; c++)
            if (c == s.lv || c == s.lv_early) dn = c + 1;
         exp_done_cyc[d] = dn;
         if (dn > 0) begin
            for (int c = 1; c <= dn; c++) exp_vec[d][c][20] = 1'b1;
            exp_vec[d][dn][19] = 1'b1;
         end
         if (dn > mx) mx = dn;
      end
      run_len = (mx + 4 < MAXC) ? mx + 4 : MAXC;
   endtask

   function automatic logic [20:0] act_vec(input int d);
      return {busy_a[d], done_a[d], rden_a[d], sr_a[d], wren_a[d],
              rden_a[d] ? addr_a[d] : 8'h00, wren_a[d] ? waddr_a[d] : 8'h00};
   endfunction

   task automatic check_zero(input string tag);
      logic [20:0] act;
      for (int d = 0; d < NC; d++) begin
         act = {busy_a[d], done_a[d], rden_a[d], sr_a[d], wren_a[d], addr_a[d], waddr_a[d]};
         vectors++;
         if (act !== 21'h0) begin
            miscompares++;
            $display("FAIL %s cfg%0d: got %h expected %h", tag, d, act, 21'h0);
         end
      end
   endtask

   task automatic run_scen(input scen_t s, input string tag);
      int pulses [NC];
      int seen_done [NC];
      logic [20:0] act;
      build_model(s);
      for (int d = 0; d < NC; d++) begin
         pulses[d] = 0;
         seen_done[d] = -1;
      end
      for (int c = 0; c < run_len; c++) begin
         @(posedge clk);
         #1;
         start    = (c == 0) || (c == s.rep_a) || (c == s.rep_b);
         last_val = (c == s.lv) || (c == s.lv_early);
`ifdef CONV_1D_CTRL_STALL_EN
         img_stall = stall_at(s, c);
`endif
         @(negedge clk);
         for (int d = 0; d < NC; d++) begin
            act = act_vec(d);
            vectors++;
            if (act !== exp_vec[d][c]) begin
               miscompares++;
               $display("FAIL %s cfg%0d cycle %0d outputs: got %h expected %h",
                        tag, d, c, act, exp_vec[d][c]);
            end
            if (wren_a[d]) pulses[d]++;
            if (done_a[d] && seen_done[d] < 0) seen_done[d] = c;
         end
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      last_val = 1'b0;
`ifdef CONV_1D_CTRL_STALL_EN
      img_stall = 1'b0;
`endif
      for (int d = 0; d < NC; d++) begin
         vectors++;
         if (pulses[d] != EXP_PULSES[d]) begin
            miscompares++;
            $display("FAIL %s cfg%0d pulse_count: got %0d expected %0d", tag, d, pulses[d], EXP_PULSES[d]);
         end
         vectors++;
         if (seen_done[d] != s.exp_done) begin
            miscompares++;
            $display("FAIL %s cfg%0d done_cycle: got %0d expected %0d", tag, d, seen_done[d], s.exp_done);
         end
      end
      $display("run %s: lv=%0d rep=%0d/%0d stall=%h done@%0d pulses %0d/%0d/%0d",
               tag, s.lv, s.rep_a, s.rep_b, s.stall_mask, s.exp_done, pulses[0], pulses[1], pulses[2]);
   endtask

   initial begin
      scen_t tbl [3];
      scen_t rs;
      logic [20:0] act;

      tbl[0] = '{lv: 14, lv_early: -1, rep_a: -1, rep_b: -1, stall_mask: 16'h0000, exp_done: 15};
      tbl[1] = '{lv: 16, lv_early: 3,  rep_a: 4,  rep_b: 12, stall_mask: 16'h0000, exp_done: 17};
      tbl[2] = '{lv: 20, lv_early: -1, rep_a: 2,  rep_b: -1, stall_mask: 16'h000C, exp_done: 21};

      repeat (3) @(posedge clk);
      @(negedge clk);
      check_zero("reset_state");
      @(posedge clk);
      #1 reset = 1'b0;

      // Abort a run mid-LOAD: outputs must clear asynchronously.
      @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int d = 0; d < NC; d++) begin
         act = {busy_a[d], rden_a[d], addr_a[d], 11'h0};
         vectors++;
         if (act !== {1'b1, 1'b1, 8'd2, 11'h0}) begin
            miscompares++;
            $display("FAIL pre_reset cfg%0d: got %h expected %h", d, act, {1'b1, 1'b1, 8'd2, 11'h0});
         end
      end
      @(posedge clk);
      #1 reset = 1'b1;
      #1 check_zero("reset_mid_run");
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < 3; i++) run_scen(tbl[i], $sformatf("table%0d", i));

      for (int i = 0; i < 6; i++) begin
         rs.lv         = int'($urandom_range(18, 26));
         rs.lv_early   = int'($urandom_range(1, 3));
         rs.rep_a      = int'($urandom_range(1, rs.lv));
         rs.rep_b      = int'($urandom_range(1, rs.lv));
         rs.stall_mask = 16'($urandom_range(0, 127) << 1);
         rs.exp_done   = rs.lv + 1;
         run_scen(rs, $sformatf("rand%0d", i));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
